// File: rtl/jc_display_select_ctrl.sv
// -----------------------------------------------------------------------------
// jc_display_select_ctrl
//   Front-panel input side of the display path. Debounces the NEXT/PREV
//   push-buttons, steps a registered view selector that drives the display
//   mux, generates the slow Display_CLK that alternates the two LED rows in
//   the Control Flags view, and lets the slide switches pick a view directly.
//
// Ports
//   CLK              in   1  system clock
//   RESET            in   1  synchronous, active-high reset
//   BTN_NEXT_N       in   1  raw push-button, active-low; advance view
//   BTN_PREV_N       in   1  raw push-button, active-low; previous view
//   SW_DIRECT        in   4  switch-entered view number
//   SW_DIRECT_EN     in   1  1 = selector follows SW_DIRECT; buttons ignored
//   JC_OUPUT_SELECT  out  4  registered view selector to display mux
//   Display_CLK      out  1  LED row toggle (1 = first row, 0 = second row)
//   SELECT_CHANGED   out  1  one-cycle pulse when JC_OUPUT_SELECT changes
// -----------------------------------------------------------------------------
module jc_display_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TOGGLE_DIV      = 12500000,
  parameter int NUM_VIEWS       = 12
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_NEXT_N,
  input  logic       BTN_PREV_N,
  input  logic [3:0] SW_DIRECT,
  input  logic       SW_DIRECT_EN,
  output logic [3:0] JC_OUPUT_SELECT,
  output logic       Display_CLK,
  output logic       SELECT_CHANGED
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TG_W = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TG_W-1:0] TG_LAST  = TG_W'(TOGGLE_DIV - 1);
  localparam logic [3:0]      SEL_LAST = 4'(NUM_VIEWS - 1);
  // One bit wider so NUM_VIEWS = 16 still compares correctly.
  localparam logic [4:0]      VIEW_LIM = 5'(NUM_VIEWS);

  // Button vectors: bit 0 = NEXT, bit 1 = PREV (active-low levels).
  logic [1:0]      btn_meta, btn_sync;
  logic [1:0]      btn_stable, btn_stable_d;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;

  logic [3:0]      sw_meta, sw_sync;
  logic            en_meta, en_sync;

  logic [3:0]      sel_next;
  logic            sel_change;
  logic [TG_W-1:0] tg_cnt;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers. Buttons reset to the released (high) level so a
  // button held through reset is seen as a fresh press afterwards.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its sources, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_meta <= 2'b11;
      btn_sync <= 2'b11;
      sw_meta  <= 4'd0;
      sw_sync  <= 4'd0;
      en_meta  <= 1'b0;
      en_sync  <= 1'b0;
    end else begin
      btn_meta <= {BTN_PREV_N, BTN_NEXT_N};
      btn_sync <= btn_meta;
      sw_meta  <= SW_DIRECT;
      sw_sync  <= sw_meta;
      en_meta  <= SW_DIRECT_EN;
      en_sync  <= en_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers: the stable level only flips after the synchronized level has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_stable   <= 2'b11;
      btn_stable_d <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      btn_stable_d <= btn_stable;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == btn_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_stable[i] <= ~btn_stable[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Stable 1->0 edge only: release and a held button produce nothing.
  assign press = btn_stable_d & ~btn_stable;

  // ---------------------------------------------------------------------------
  // Next selector value. Direct mode overrides the buttons; simultaneous
  // NEXT and PREV presses cancel.
  // ---------------------------------------------------------------------------
  // NOTE: sel_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_next = JC_OUPUT_SELECT;
    if (en_sync) begin
      sel_next = ({1'b0, sw_sync} < VIEW_LIM) ? sw_sync : 4'd0;
    end else if (press == 2'b01) begin
      sel_next = (JC_OUPUT_SELECT == SEL_LAST) ? 4'd0 : JC_OUPUT_SELECT + 4'd1;
    end else if (press == 2'b10) begin
      sel_next = (JC_OUPUT_SELECT == 4'd0) ? SEL_LAST : JC_OUPUT_SELECT - 4'd1;
    end
  end

  assign sel_change = (sel_next != JC_OUPUT_SELECT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      JC_OUPUT_SELECT <= 4'd0;
      SELECT_CHANGED  <= 1'b0;
    end else begin
      JC_OUPUT_SELECT <= sel_next;
      SELECT_CHANGED  <= sel_change;
    end
  end

  // ---------------------------------------------------------------------------
  // Row-toggle prescaler. A selector change restarts it on the first row in
  // the same cycle the new selector value appears.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tg_cnt      <= '0;
      Display_CLK <= 1'b0;
    end else if (sel_change) begin
      tg_cnt      <= '0;
      Display_CLK <= 1'b1;
    end else if (tg_cnt == TG_LAST) begin
      tg_cnt      <= '0;
      Display_CLK <= ~Display_CLK;
    end else begin
      tg_cnt <= tg_cnt + TG_W'(1);
    end
  end

endmodule
